// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider, one bit per cycle.
// Define MULDIV_SIGNED_EN to add the op_signed port for signed operations.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
`ifdef MULDIV_SIGNED_EN
  input  logic             op_signed,
`endif
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic [1:0]       flag
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic op_q, op_d, sgn_q, sgn_d, neg_q, neg_d, rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic [1:0] flag_q, flag_d;
  logic sgn_in, a_neg, b_neg, accept, div0, mul_ovf;
  logic [WIDTH-1:0] a_mag, b_mag, it_hi, it_lo, quo, rem;
  logic [WIDTH:0] mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod, sprod;
`ifdef MULDIV_SIGNED_EN
  assign sgn_in = op_signed;
`else
  assign sgn_in = 1'b0;
`endif
  assign a_neg  = sgn_in & data_a[WIDTH-1];
  assign b_neg  = sgn_in & data_b[WIDTH-1];
  assign a_mag  = a_neg ? -data_a : data_a;
  assign b_mag  = b_neg ? -data_b : data_b;
  assign accept = start && state_q != RUN;
  assign div0   = op && data_b == '0;
  // Multiply shifts {hi,lo} right; divide shifts {rem,quotient} left.
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_sh   = {hi_q, lo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign it_hi = op_q ? (div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0]) : mul_sum[WIDTH:1];
  assign it_lo = op_q ? {lo_q[WIDTH-2:0], ~div_diff[WIDTH]} : {mul_sum[0], lo_q[WIDTH-1:1]};
  // Signs are applied to the last iteration's value so results land in DONE without an extra cycle.
  assign prod    = {it_hi, it_lo};
  assign sprod   = neg_q ? -prod : prod;
  assign quo     = neg_q ? -it_lo : it_lo;
  assign rem     = rneg_q ? -it_hi : it_hi;
  assign mul_ovf = sgn_q ? sprod[2*WIDTH-1:WIDTH] != {WIDTH{sprod[WIDTH-1]}} : it_hi != '0;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sgn_d    = sgn_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    flag_d   = flag_q;
    if (accept) begin
      op_d   = op;
      sgn_d  = sgn_in;
      neg_d  = a_neg ^ b_neg;
      rneg_d = a_neg;
      cnt_d  = '0;
      hi_d   = '0;
      lo_d   = op ? a_mag : b_mag;
      opnd_d = op ? b_mag : a_mag;
      state_d = div0 ? DONE : RUN;
      if (div0) begin
        res_hi_d = data_a;
        res_lo_d = '1;
        flag_d   = 2'b10;
      end
    end else if (state_q == RUN) begin
      hi_d  = it_hi;
      lo_d  = it_lo;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_d  = DONE;
        res_hi_d = op_q ? rem : sprod[2*WIDTH-1:WIDTH];
        res_lo_d = op_q ? quo : sprod[WIDTH-1:0];
        flag_d   = {1'b0, ~op_q & mul_ovf};
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      flag_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sgn_q    <= sgn_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      flag_q   <= flag_d;
    end
  end
  assign busy      = state_q == RUN;
  assign done      = state_q == DONE;
  assign result_hi = res_hi_q;
  assign result_lo = res_lo_q;
  assign flag      = flag_q;
endmodule
